// File: rtl/ps2_keyboard_pkg.sv
// Shared constants for the PS/2 keyboard reader: frame FSM encoding, register
// offsets, scan-code prefixes and STATUS register layout.
package ps2_keyboard_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [2:0] DATA_OFS   = 3'd0;
  localparam logic [2:0] STATUS_OFS = 3'd4;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  localparam int STAT_COUNT_LSB = 0;
  localparam int STAT_FERR_BIT  = 3;
  localparam int STAT_OVF_BIT   = 4;

  typedef struct packed {
    logic       overflow;
    logic       frame_error;
    logic [2:0] count;
  } status_t;

  // Odd parity: data bits plus the parity bit must hold an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

  // FIFO occupancy as shown in STATUS, clamped to the 3-bit field.
  function automatic logic [2:0] sat_count(input int unsigned c);
    return (c > 7) ? 3'd7 : c[2:0];
  endfunction

endpackage

// File: rtl/ps2_frame_receiver.sv
// PS/2 line synchronizers, falling-edge detect, 11-bit frame FSM and stall
// timeout. Emits one strobe per good byte and one per malformed frame.
module ps2_frame_receiver
  import ps2_keyboard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] byte_out,
  output logic       byte_strobe,
  output logic       frame_err_strobe
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
  logic ps2_dat_p0, ps2_dat_p1;
  logic fall, bit_in;

  logic [1:0]      state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            parity_bit;
  logic [TO_W-1:0] to_cnt;
  logic            timeout;
  logic            stop_edge, frame_good;

  // Stage p0/p1: two-flop synchronizers; p2: clock history for edge detect.
  // Lines idle high, so reset loads ones to avoid a false edge on release.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ps2_clk_p0 <= 1'b1;
      ps2_clk_p1 <= 1'b1;
      ps2_clk_p2 <= 1'b1;
      ps2_dat_p0 <= 1'b1;
      ps2_dat_p1 <= 1'b1;
    end else begin
      ps2_clk_p0 <= ps2_clk;
      ps2_clk_p1 <= ps2_clk_p0;
      ps2_clk_p2 <= ps2_clk_p1;
      ps2_dat_p0 <= ps2_dat;
      ps2_dat_p1 <= ps2_dat_p0;
    end
  end

  assign fall    = ps2_clk_p2 & ~ps2_clk_p1;
  assign bit_in  = ps2_dat_p1;
  assign timeout = (state != ST_IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      if (fall || state == ST_IDLE) to_cnt <= '0;
      else if (!timeout)            to_cnt <= to_cnt + 1'b1;

      if (fall) begin
        case (state)
          ST_IDLE: if (!bit_in) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
          ST_DATA: begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: state <= ST_STOP;
          default:   state <= ST_IDLE;
        endcase
      end else if (timeout) begin
        state <= ST_IDLE;
      end
    end
  end

  // Payload registers carry no reset; the FSM decides when they are meaningful.
  always_ff @(posedge clk) begin
    if (fall && state == ST_DATA)   shift      <= {bit_in, shift[7:1]};
    if (fall && state == ST_PARITY) parity_bit <= bit_in;
  end

  assign stop_edge  = fall && (state == ST_STOP);
  assign frame_good = bit_in && parity_ok(shift, parity_bit);

  assign byte_out         = shift;
  assign byte_strobe      = stop_edge && frame_good;
  assign frame_err_strobe = (stop_edge && !frame_good) ||
                            (fall && (state == ST_IDLE) && bit_in);

endmodule

// File: rtl/ps2_keyboard_reader.sv
// Memory-mapped PS/2 keyboard reader: frame receiver, scan-code FIFO, DATA and
// STATUS registers, irq. Define PS2_BREAK_FILTER_EN to keep only make codes.
module ps2_keyboard_reader
  import ps2_keyboard_pkg::*;
#(
  parameter int          WORD_SIZE      = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h00030000,
  parameter int          FIFO_DEPTH     = 8,
  parameter int          TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ps2_clk,
  input  logic                 ps2_dat,
  input  logic [31:0]          address,
  input  logic                 read_en,
  input  logic                 write_en,
  input  logic [WORD_SIZE-1:0] write_word,
  output logic [WORD_SIZE-1:0] word_output,
  output logic                 read_valid,
  output logic                 irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0] byte_out;
  logic       byte_strobe, frame_err_strobe;
  logic       push_req;

  ps2_frame_receiver #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk             (clk),
    .rst             (rst),
    .ps2_clk         (ps2_clk),
    .ps2_dat         (ps2_dat),
    .byte_out        (byte_out),
    .byte_strobe     (byte_strobe),
    .frame_err_strobe(frame_err_strobe)
  );

`ifdef PS2_BREAK_FILTER_EN
  logic break_pending;

  // A break prefix swallows itself and the next non-E0 byte (the released key).
  always_ff @(posedge clk) begin
    if (!rst) begin
      break_pending <= 1'b0;
    end else if (byte_strobe) begin
      if (byte_out == BREAK_CODE)  break_pending <= 1'b1;
      else if (byte_out != EXT_CODE) break_pending <= 1'b0;
    end
  end

  assign push_req = byte_strobe && !break_pending &&
                    (byte_out != BREAK_CODE) && (byte_out != EXT_CODE);
`else
  assign push_req = byte_strobe;
`endif

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_empty, fifo_full;
  logic             in_window, rd_data, rd_status, wr_status;
  logic             pop, push, overflow_set;
  logic             overflow, frame_error;
  logic             clr_ovf, clr_ferr;
  status_t          status;

  assign in_window = (address[31:3] == BASE_ADDR[31:3]);
  assign rd_data   = read_en  && in_window && (address[2] == DATA_OFS[2]);
  assign rd_status = read_en  && in_window && (address[2] == STATUS_OFS[2]);
  assign wr_status = write_en && in_window && (address[2] == STATUS_OFS[2]);

  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == CNT_W'(FIFO_DEPTH));
  assign pop          = rd_data && !fifo_empty;
  assign push         = push_req && (!fifo_full || pop);
  assign overflow_set = push_req && fifo_full && !pop;

  assign clr_ovf  = wr_status && write_word[STAT_OVF_BIT];
  assign clr_ferr = wr_status && write_word[STAT_FERR_BIT];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= byte_out;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (overflow_set)     overflow <= 1'b1;
      else if (clr_ovf)     overflow <= 1'b0;
      if (frame_err_strobe) frame_error <= 1'b1;
      else if (clr_ferr)    frame_error <= 1'b0;
    end
  end

  always_comb begin
    status             = '0;
    status.overflow    = overflow;
    status.frame_error = frame_error;
    status.count       = sat_count(32'(count));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      word_output <= '0;
      read_valid  <= 1'b0;
    end else begin
      read_valid <= rd_data || rd_status;
      if (rd_data)        word_output <= pop ? WORD_SIZE'({1'b1, mem[rd_ptr]}) : '0;
      else if (rd_status) word_output <= WORD_SIZE'(status);
    end
  end

  assign irq = !fifo_empty;

  // Address byte-lane bits and unused write bits are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{address[1:0], write_word};

endmodule

// File: tb/tb_ps2_keyboard_reader.sv
// Scoreboard bench for ps2_keyboard_reader: bytes queued when frames are sent,
// popped and compared as DATA reads return.
module tb_ps2_keyboard_reader;

  localparam int          TO   = 200;
  localparam int          HALF = 10;
  localparam logic [31:0] BASE = 32'h00030000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [31:0] address = '0;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic [31:0] write_word = '0;
  logic [31:0] word_output;
  logic        read_valid;
  logic        irq;

  ps2_keyboard_reader #(
    .WORD_SIZE(32), .BASE_ADDR(BASE), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .address(address), .read_en(read_en), .write_en(write_en),
    .write_word(write_word), .word_output(word_output),
    .read_valid(read_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_q[$];
  logic        exp_fe  = 1'b0;
  logic        exp_ovf = 1'b0;
  logic [31:0] last_word = '0;
`ifdef PS2_BREAK_FILTER_EN
  logic        brk_pend = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_push(input logic [7:0] b);
`ifdef PS2_BREAK_FILTER_EN
    if (b == 8'hE0) return;
    if (b == 8'hF0) begin brk_pend = 1'b1; return; end
    if (brk_pend)   begin brk_pend = 1'b0; return; end
`endif
    if (exp_q.size() < 8) exp_q.push_back(b);
    else                  exp_ovf = 1'b1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    repeat (HALF) @(posedge clk);
    #1;
    if (bad_par) exp_fe = 1'b1;
    else         model_push(b);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic vld);
    address = addr;
    read_en = 1'b1;
    @(posedge clk);
    #1 read_en = 1'b0;
    @(negedge clk);
    data = word_output;
    vld  = read_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] w);
    address    = addr;
    write_word = w;
    write_en   = 1'b1;
    @(posedge clk);
    #1 write_en = 1'b0;
    if (addr[2]) begin
      if (w[4]) exp_ovf = 1'b0;
      if (w[3]) exp_fe  = 1'b0;
    end
  endtask

  task automatic read_data(input string tag);
    logic [31:0] d, e;
    logic        v;
    bus_read(BASE, d, v);
    check({tag, "_vld"}, {31'b0, v}, 32'd1);
    e = (exp_q.size() > 0) ? {23'b0, 1'b1, exp_q.pop_front()} : 32'h0;
    check(tag, d, e);
    last_word = e;
  endtask

  task automatic read_status(input string tag, input logic [31:0] addr);
    logic [31:0] d, e;
    logic        v;
    int          n;
    bus_read(addr, d, v);
    n = exp_q.size();
    e = {27'b0, exp_ovf, exp_fe, (n > 7) ? 3'd7 : 3'(n)};
    check({tag, "_vld"}, {31'b0, v}, 32'd1);
    check(tag, d, e);
    last_word = e;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        v;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_word", word_output, 32'h0);
    check("rst_valid", {31'b0, read_valid}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single good frame
    send_frame(8'h1C, 1'b0);
    check("irq_hi", {31'b0, irq}, 32'd1);
    read_status("stat_one", BASE + 32'd6);
    read_data("data_1c");
    check("data_1c_const", last_word, 32'h0000011C);
    check("irq_lo", {31'b0, irq}, 32'd0);
    read_status("stat_empty", BASE + 32'd4);

    // Bad parity, then clear frame_error
    send_frame(8'h1C, 1'b1);
    read_status("stat_ferr", BASE + 32'd4);
    bus_write(BASE + 32'd4, 32'h08);
    read_status("stat_ferr_clr", BASE + 32'd4);

    // Overflow: nine frames, no reads
    for (int i = 0; i < 9; i++) send_frame(8'h30 + 8'(i), 1'b0);
    read_status("stat_full", BASE + 32'd4);
    for (int i = 0; i < 8; i++) read_data("data_fifo");
    read_data("data_empty");
    bus_write(BASE + 32'd4, 32'h10);
    read_status("stat_ovf_clr", BASE + 32'd4);

    // Stalled frame abandoned by timeout, then a full frame
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TO + 40) @(posedge clk);
    #1;
    send_frame(8'h2A, 1'b0);
    read_status("stat_timeout", BASE + 32'd4);
    read_data("data_2a");

    // Out-of-window read: no pop, no response, output held
    send_frame(8'h5B, 1'b0);
    bus_read(BASE + 32'd8, d, v);
    check("oow_vld", {31'b0, v}, 32'd0);
    check("oow_hold", d, last_word);
    read_status("stat_oow", BASE + 32'd4);
    read_data("data_5b");

    // Reset in the middle of a frame with bytes queued
    for (int i = 0; i < 3; i++) send_frame(8'h60 + 8'(i), 1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    exp_fe = 1'b0;
    exp_ovf = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
    brk_pend = 1'b0;
`endif
    check("rst_mid_irq", {31'b0, irq}, 32'd0);
    read_status("stat_rst_mid", BASE + 32'd4);
    send_frame(8'h45, 1'b0);
    read_data("data_45");

    // Extended / break sequence
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    send_frame(8'h1C, 1'b0);
    read_status("stat_brk", BASE + 32'd4);
    while (exp_q.size() > 0) read_data("data_brk");
    read_data("data_brk_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
